ttt_turn_controller: RTL and testbench

//  Sequencer for the tic-tac-toe board datapath: nine 2-bit position registers plus the combinational win validator.

---
 rtl/ttt_pkg.sv | 34 +++
 rtl/ttt_turn_timer.sv | 29 ++
 rtl/ttt_turn_controller.sv | 136 +++++++++++++
 tb/tb_ttt_turn_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types, constants and helpers for the tic-tac-toe turn controller slice.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_MOVE,
    WRITE,
    CHECK,
    GAME_OVER
  } state_t;

  localparam int unsigned N_CELLS          = 9;
  localparam int unsigned CELL_ILLEGAL_MIN = 9;

  function automatic logic [3:0] first_empty(input logic [2*N_CELLS-1:0] board);
    logic found;
    first_empty = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (!found && board[2*i +: 2] == EMPTY) begin
        first_empty = 4'(i);
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/ttt_turn_timer.sv
// Per-turn cycle counter; saturates at TURN_TIMEOUT-1 and flags expiry there.
module ttt_turn_timer #(
  parameter int unsigned TURN_TIMEOUT = 500_000_000,
  parameter int unsigned TIMER_W      = 29
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TURN_TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != LAST) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/ttt_turn_controller.sv
// Turn sequencer: move handshake, legality check, board write enables, win/draw and timeout auto-move.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 500_000_000,
  parameter int unsigned TIMER_W      = 29
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  output logic        move_ready,
  input  logic [17:0] board_state,
  input  logic        win_in,
  output logic [8:0]  board_en,
  output logic [1:0]  board_wr_id,
  output logic        board_clr,
  output logic [1:0]  current_player,
  output logic [3:0]  move_count,
  output logic        move_reject,
  output logic        timeout_pulse,
  output logic        game_over,
  output logic [1:0]  winner
);

  state_t     state;
  logic       cell_free;
  logic       pos_ok;
  logic       hs;
  logic       legal;
  logic       expired;
  logic       timer_clr;
  logic       timer_en;
  logic [3:0] auto_pos;

  always_comb begin
    cell_free = 1'b0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (move_pos == 4'(i)) cell_free = (board_state[2*i +: 2] == EMPTY);
    end
  end

  assign pos_ok    = (move_pos < 4'(CELL_ILLEGAL_MIN));
  assign hs        = move_valid && (state == WAIT_MOVE);
  assign legal     = hs && pos_ok && cell_free;
  assign auto_pos  = first_empty(board_state);
  assign timer_en  = (state == WAIT_MOVE);
  assign timer_clr = (state != WAIT_MOVE) || legal;

  ttt_turn_timer #(
    .TURN_TIMEOUT (TURN_TIMEOUT),
    .TIMER_W      (TIMER_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      move_ready     <= 1'b0;
      board_en       <= '0;
      board_wr_id    <= '0;
      board_clr      <= 1'b0;
      current_player <= '0;
      move_count     <= '0;
      move_reject    <= 1'b0;
      timeout_pulse  <= 1'b0;
      game_over      <= 1'b0;
      winner         <= '0;
    end else begin
      board_en      <= '0;
      board_clr     <= 1'b0;
      move_reject   <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start) begin
            state          <= CLEAR;
            board_clr      <= 1'b1;
            move_count     <= '0;
            current_player <= P1;
            game_over      <= 1'b0;
            winner         <= EMPTY;
          end
        end
        CLEAR: begin
          state      <= WAIT_MOVE;
          move_ready <= 1'b1;
        end
        WAIT_MOVE: begin
          // The latched position lives only in board_en; WRITE needs nothing else.
          if (legal) begin
            state       <= WRITE;
            move_ready  <= 1'b0;
            board_en    <= 9'b1 << move_pos;
            board_wr_id <= current_player;
          end else if (expired) begin
            state         <= WRITE;
            move_ready    <= 1'b0;
            board_en      <= 9'b1 << auto_pos;
            board_wr_id   <= current_player;
            timeout_pulse <= 1'b1;
          end else if (hs) begin
            move_reject <= 1'b1;
          end
        end
        WRITE: begin
          move_count <= move_count + 4'd1;
          state      <= CHECK;
        end
        CHECK: begin
          if (win_in) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
            winner    <= current_player;
          end else if (move_count == 4'(N_CELLS)) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
            winner    <= EMPTY;
          end else begin
            current_player <= (current_player == P1) ? P2 : P1;
            move_ready     <= 1'b1;
            state          <= WAIT_MOVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Bench for ttt_turn_controller: board datapath emulation, game-level reference model, directed and random play.
module tb_ttt_turn_controller;

  localparam int T = 16;
  localparam int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_WAIT = 2, PH_WRITE = 3, PH_CHECK = 4, PH_OVER = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        move_valid = 1'b0;
  logic [3:0]  move_pos = 4'd0;
  logic        move_ready;
  logic [17:0] board_state;
  logic        win_in;
  logic [8:0]  board_en;
  logic [1:0]  board_wr_id;
  logic        board_clr;
  logic [1:0]  current_player;
  logic [3:0]  move_count;
  logic        move_reject;
  logic        timeout_pulse;
  logic        game_over;
  logic [1:0]  winner;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ttt_turn_controller #(
    .TURN_TIMEOUT (T),
    .TIMER_W      (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .move_valid     (move_valid),
    .move_pos       (move_pos),
    .move_ready     (move_ready),
    .board_state    (board_state),
    .win_in         (win_in),
    .board_en       (board_en),
    .board_wr_id    (board_wr_id),
    .board_clr      (board_clr),
    .current_player (current_player),
    .move_count     (move_count),
    .move_reject    (move_reject),
    .timeout_pulse  (timeout_pulse),
    .game_over      (game_over),
    .winner         (winner)
  );

  // Position registers and win validator that the controller drives
  logic [1:0] cells [9];

  always @(posedge clock) begin
    for (int i = 0; i < 9; i++) begin
      if (board_clr) cells[i] <= 2'b00;
      else if (board_en[i]) cells[i] <= board_wr_id;
    end
  end

  always_comb begin
    board_state = '0;
    win_in      = 1'b0;
    for (int i = 0; i < 9; i++) board_state[2*i +: 2] = cells[i];
    for (int l = 0; l < 8; l++) begin
      if (cells[LN[l][0]] != 2'b00 && cells[LN[l][0]] == cells[LN[l][1]] &&
          cells[LN[l][1]] == cells[LN[l][2]]) win_in = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game rules over its own board copy
  int ph, mtim, mpos;
  int mb [9];
  int e_ready, e_en, e_id, e_clr, e_pl, e_cnt, e_rej, e_to, e_over, e_win;

  function automatic bit mwin(input int p);
    bit w = 0;
    for (int l = 0; l < 8; l++)
      if (mb[LN[l][0]] == p && mb[LN[l][1]] == p && mb[LN[l][2]] == p) w = 1;
    return w;
  endfunction

  task automatic mreset();
    ph = PH_IDLE; mtim = 0;
    e_ready = 0; e_en = 0; e_id = 0; e_clr = 0; e_pl = 0;
    e_cnt = 0; e_rej = 0; e_to = 0; e_over = 0; e_win = 0;
  endtask

  task automatic mstep();
    bit legal;
    e_en = 0; e_clr = 0; e_rej = 0; e_to = 0;
    case (ph)
      PH_IDLE, PH_OVER: if (start) begin
        ph = PH_CLEAR; e_clr = 1; e_cnt = 0; e_pl = 1; e_over = 0; e_win = 0;
      end
      PH_CLEAR: begin
        for (int i = 0; i < 9; i++) mb[i] = 0;
        ph = PH_WAIT; mtim = 0; e_ready = 1;
      end
      PH_WAIT: begin
        legal = 0;
        if (move_valid && move_pos <= 8) legal = (mb[move_pos] == 0);
        if (legal || mtim == T - 1) begin
          if (legal) mpos = int'(move_pos);
          else begin
            mpos = -1;
            for (int i = 8; i >= 0; i--) if (mb[i] == 0) mpos = i;
            e_to = 1;
          end
          e_en = 1 << mpos; e_id = e_pl; e_ready = 0; ph = PH_WRITE;
        end else begin
          if (move_valid) e_rej = 1;
          if (mtim < T - 1) mtim++;
        end
      end
      PH_WRITE: begin
        mb[mpos] = e_pl; e_cnt++; ph = PH_CHECK;
      end
      PH_CHECK: begin
        if (mwin(e_pl)) begin
          ph = PH_OVER; e_over = 1; e_win = e_pl;
        end else if (e_cnt == 9) begin
          ph = PH_OVER; e_over = 1; e_win = 0;
        end else begin
          e_pl = 3 - e_pl; mtim = 0; ph = PH_WAIT; e_ready = 1;
        end
      end
      default: ph = PH_IDLE;
    endcase
  endtask

  initial begin
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mreset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) mreset();
      else mstep();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("move_ready", int'(move_ready), e_ready);
        check("board_en", int'(board_en), e_en);
        if (e_en != 0) check("board_wr_id", int'(board_wr_id), e_id);
        check("board_clr", int'(board_clr), e_clr);
        check("current_player", int'(current_player), e_pl);
        check("move_count", int'(move_count), e_cnt);
        check("move_reject", int'(move_reject), e_rej);
        check("timeout_pulse", int'(timeout_pulse), e_to);
        check("game_over", int'(game_over), e_over);
        check("winner", int'(winner), e_win);
      end
    end
  end

  task automatic wait_ready();
    for (int n = 0; n < 64 && !move_ready; n++) @(negedge clock);
    check("ready_wait", int'(move_ready), 1);
  endtask

  task automatic do_move(input int p, output int en);
    wait_ready();
    move_valid = 1'b1;
    move_pos   = 4'(p);
    @(negedge clock);
    en = int'(board_en);
    move_valid = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int en, k, quiet;
    int seq2 [5] = '{0, 3, 1, 4, 2};
    int seq5 [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    // Reset and start
    repeat (3) @(negedge clock);
    check("rst_move_ready", int'(move_ready), 0);
    check("rst_player", int'(current_player), 0);
    check("rst_board_en", int'(board_en), 0);
    check("rst_game_over", int'(game_over), 0);
    reset = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("clr_pulse", int'(board_clr), 1);
    check("clr_player", int'(current_player), 1);
    @(negedge clock);
    check("clr_done", int'(board_clr), 0);
    check("first_ready", int'(move_ready), 1);

    // P1 wins along the top row
    for (int i = 0; i < 5; i++) begin
      do_move(seq2[i], en);
      if (i == 0) begin
        check("first_en", en, 9'h001);
        check("first_id", int'(board_wr_id), 1);
      end
    end
    repeat (2) @(negedge clock);
    check("win_over", int'(game_over), 1);
    check("win_winner", int'(winner), 1);
    check("win_count", int'(move_count), 5);

    // Rejections: occupied cell, then out-of-range, then a legal cell
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    do_move(4, en);
    wait_ready();
    move_valid = 1'b1;
    move_pos   = 4'd4;
    @(negedge clock);
    check("rej_occupied", int'(move_reject), 1);
    check("rej_player", int'(current_player), 2);
    check("rej_cell4", int'(cells[4]), 1);
    move_pos = 4'd12;
    @(negedge clock);
    check("rej_range", int'(move_reject), 1);
    move_pos = 4'd5;
    @(negedge clock);
    check("acc_en", int'(board_en), 9'h020);
    move_valid = 1'b0;

    // Timeout auto-move, then a legal move on the expiry cycle
    restart();
    do_move(0, en);
    do_move(1, en);
    wait_ready();
    k = 0;
    for (int n = 1; n <= 40 && k == 0; n++) begin
      @(negedge clock);
      if (timeout_pulse) k = n;
    end
    check("to_cycles", k, T);
    check("to_en", int'(board_en), 9'h004);
    repeat (2) @(negedge clock);
    check("to_toggle", int'(current_player), 2);
    repeat (T - 1) @(negedge clock);
    move_valid = 1'b1;
    move_pos   = 4'd7;
    @(negedge clock);
    move_valid = 1'b0;
    check("race_en", int'(board_en), 9'h080);
    check("race_no_to", int'(timeout_pulse), 0);

    // Full board, no line: draw
    restart();
    for (int i = 0; i < 9; i++) do_move(seq5[i], en);
    repeat (2) @(negedge clock);
    check("draw_over", int'(game_over), 1);
    check("draw_winner", int'(winner), 0);
    check("draw_count", int'(move_count), 9);

    // Reset during WRITE aborts immediately
    restart();
    wait_ready();
    move_valid = 1'b1;
    move_pos   = 4'd0;
    @(negedge clock);
    move_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort_en", int'(board_en), 0);
    check("abort_player", int'(current_player), 0);
    check("abort_count", int'(move_count), 0);
    check("abort_ready", int'(move_ready), 0);
    check("abort_over", int'(game_over), 0);
    @(negedge clock);
    reset = 1'b1;
    check("abort_cell0", int'(cells[0]), 0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("abort_clr", int'(board_clr), 1);
    check("abort_fresh", int'(current_player), 1);

    // Random play against the model
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom % 16 == 0);
      if ($urandom % 50 == 0) quiet = 20;
      if (quiet > 0) begin
        quiet--;
        move_valid = 1'b0;
      end else begin
        move_valid = ($urandom % 3 == 0);
      end
      move_pos = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'($urandom % 9);
      @(negedge clock);
    end
    start      = 1'b0;
    move_valid = 1'b0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
